// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared types and constants for the memory request arbiter
package mem_req_arbiter_pkg;

  localparam int unsigned PortIcache = 0;
  localparam int unsigned PortDcache = 1;

  // Payload fields are sized for the widest supported configuration; instances cast down.
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxDataWidth = 512;
  localparam int unsigned MaxTidWidth  = 8;
  localparam int unsigned PortIdxWidth = 8;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic                    we;
    logic [MaxDataWidth-1:0] wdata;
    logic [MaxTidWidth-1:0]  tid;
  } mem_req_t;

  typedef struct packed {
    logic                    used;
    logic [PortIdxWidth-1:0] port;
  } tid_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant
// The pointer moves to one past the granted port only when update_i marks the grant as used.
module rr_arbiter #(
  parameter int unsigned NrPorts = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrPorts-1:0] req_i,
  input  logic               update_i,
  output logic [NrPorts-1:0] gnt_o
);

  localparam int unsigned PtrWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic [PtrWidth-1:0] gnt_idx;
  logic                found;
  int unsigned         idx;

  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < NrPorts; off++) begin
      idx = (32'(ptr_q) + off) % NrPorts;
      if (req_i[idx] && !found) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx    = PtrWidth'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && found) begin
      ptr_d = (gnt_idx == PtrWidth'(NrPorts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - N-port memory request arbiter with TID tracking and response routing
// Optional perf counters are compiled in with MEM_REQ_ARBITER_PERF_EN.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrPorts-1:0]                req_valid_i,
  output logic [NrPorts-1:0]                req_ready_o,
  input  logic [NrPorts-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NrPorts-1:0]                req_we_i,
  input  logic [NrPorts-1:0][DataWidth-1:0] req_wdata_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [AddrWidth-1:0]              mem_req_addr_o,
  output logic                              mem_req_we_o,
  output logic [DataWidth-1:0]              mem_req_wdata_o,
  output logic [TidWidth-1:0]               mem_req_tid_o,
  input  logic                              mem_rsp_valid_i,
  input  logic [TidWidth-1:0]               mem_rsp_tid_i,
  input  logic [DataWidth-1:0]              mem_rsp_data_i,
  output logic [NrPorts-1:0]                rsp_valid_o,
  output logic [DataWidth-1:0]              rsp_data_o,
  output logic [TidWidth:0]                 outstanding_o,
  output logic                              err_o
`ifdef MEM_REQ_ARBITER_PERF_EN
  ,
  output logic [NrPorts-1:0][31:0]          perf_grant_cnt_o,
  output logic [NrPorts-1:0][31:0]          perf_stall_cnt_o
`endif
);

  localparam int unsigned NrTids = 2 ** TidWidth;

  tid_entry_t tid_tbl_q [NrTids];
  tid_entry_t tid_tbl_d [NrTids];
  tid_entry_t rsp_entry;
  mem_req_t   out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;

  logic [NrPorts-1:0]      gnt;
  logic                    free_avail;
  logic [TidWidth-1:0]     free_tid;
  logic                    can_load;
  logic                    accept;
  logic                    rsp_hit;
  logic [PortIdxWidth-1:0] gnt_port;
  logic [AddrWidth-1:0]    sel_addr;
  logic                    sel_we;
  logic [DataWidth-1:0]    sel_wdata;
  logic [TidWidth:0]       used_cnt;

  rr_arbiter #(
    .NrPorts(NrPorts)
  ) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_valid_i),
    .update_i(accept),
    .gnt_o   (gnt)
  );

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    free_avail = 1'b0;
    free_tid   = '0;
    for (int t = NrTids - 1; t >= 0; t--) begin
      if (!tid_tbl_q[t].used) begin
        free_avail = 1'b1;
        free_tid   = TidWidth'(t);
      end
    end
  end

  always_comb begin
    used_cnt = '0;
    for (int t = 0; t < NrTids; t++) begin
      used_cnt = used_cnt + {{TidWidth{1'b0}}, tid_tbl_q[t].used};
    end
  end

  always_comb begin
    gnt_port  = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int p = 0; p < NrPorts; p++) begin
      if (gnt[p]) begin
        gnt_port  = PortIdxWidth'(p);
        sel_addr  = req_addr_i[p];
        sel_we    = req_we_i[p];
        sel_wdata = req_wdata_i[p];
      end
    end
  end

  assign can_load    = !out_valid_q || mem_req_ready_i;
  assign req_ready_o = gnt & {NrPorts{free_avail && can_load}};
  assign accept      = |req_ready_o;

  assign rsp_entry = tid_tbl_q[mem_rsp_tid_i];
  assign rsp_hit   = mem_rsp_valid_i && rsp_entry.used;

  always_comb begin
    rsp_valid_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = rsp_hit && (rsp_entry.port == PortIdxWidth'(p));
    end
  end

  // Release happens before allocation; the allocated TID was free this cycle so they never collide.
  always_comb begin
    tid_tbl_d = tid_tbl_q;
    if (rsp_hit) begin
      tid_tbl_d[mem_rsp_tid_i].used = 1'b0;
    end
    if (accept) begin
      tid_tbl_d[free_tid].used = 1'b1;
      tid_tbl_d[free_tid].port = gnt_port;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_d       = err_q | (mem_rsp_valid_i & ~rsp_entry.used);
    if (accept) begin
      out_valid_d = 1'b1;
      out_d.addr  = MaxAddrWidth'(sel_addr);
      out_d.we    = sel_we;
      out_d.wdata = MaxDataWidth'(sel_wdata);
      out_d.tid   = MaxTidWidth'(free_tid);
    end else if (mem_req_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
      for (int t = 0; t < NrTids; t++) begin
        tid_tbl_q[t] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
      for (int t = 0; t < NrTids; t++) begin
        tid_tbl_q[t] <= tid_tbl_d[t];
      end
    end
  end

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_addr_o  = AddrWidth'(out_q.addr);
  assign mem_req_we_o    = out_q.we;
  assign mem_req_wdata_o = DataWidth'(out_q.wdata);
  assign mem_req_tid_o   = TidWidth'(out_q.tid);
  assign rsp_data_o      = mem_rsp_data_i;
  assign outstanding_o   = used_cnt;
  assign err_o           = err_q;

`ifdef MEM_REQ_ARBITER_PERF_EN
  logic [NrPorts-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [NrPorts-1:0][31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int p = 0; p < NrPorts; p++) begin
      if (req_valid_i[p] && req_ready_o[p]) begin
        grant_cnt_d[p] = sat_inc(grant_cnt_q[p]);
      end else if (req_valid_i[p]) begin
        stall_cnt_d[p] = sat_inc(stall_cnt_q[p]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt_o = grant_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - table-driven self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][63:0] req_addr;
  logic [1:0]       req_we;
  logic [1:0][63:0] req_wdata;
  logic             mem_valid;
  logic             mem_ready;
  logic [63:0]      mem_addr;
  logic             mem_we;
  logic [63:0]      mem_wdata;
  logic [1:0]       mem_tid;
  logic             rsp_vin;
  logic [1:0]       rsp_tin;
  logic [63:0]      rsp_din;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_data;
  logic [2:0]       outstanding;
  logic             err;
`ifdef MEM_REQ_ARBITER_PERF_EN
  logic [1:0][31:0] perf_grant;
  logic [1:0][31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NrPorts(2), .AddrWidth(64), .DataWidth(64), .TidWidth(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_we_i       (req_we),
    .req_wdata_i    (req_wdata),
    .mem_req_valid_o(mem_valid),
    .mem_req_ready_i(mem_ready),
    .mem_req_addr_o (mem_addr),
    .mem_req_we_o   (mem_we),
    .mem_req_wdata_o(mem_wdata),
    .mem_req_tid_o  (mem_tid),
    .mem_rsp_valid_i(rsp_vin),
    .mem_rsp_tid_i  (rsp_tin),
    .mem_rsp_data_i (rsp_din),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .outstanding_o  (outstanding),
    .err_o          (err)
`ifdef MEM_REQ_ARBITER_PERF_EN
    ,
    .perf_grant_cnt_o(perf_grant),
    .perf_stall_cnt_o(perf_stall)
`endif
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic       mr;
    logic       rv;
    logic [1:0] rt;
    logic [1:0] rdy;
    logic [1:0] rsp;
    logic [2:0] out;
    logic       mv;
    logic       err;
    logic [1:0] tid;
    logic       hold;
  } row_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [1:0]  tid;
  } exp_t;

  row_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] v, input logic mr, input logic rv,
                     input logic [1:0] rt, input logic [1:0] rdy, input logic [1:0] rsp,
                     input logic [2:0] out, input logic mv, input logic e,
                     input logic [1:0] tid, input logic hold);
    row_t x;
    x = '{rst: r, v: v, mr: mr, rv: rv, rt: rt, rdy: rdy, rsp: rsp, out: out,
          mv: mv, err: e, tid: tid, hold: hold};
    tbl.push_back(x);
  endtask

  task automatic apply(input row_t r, input int idx);
    exp_t e;
    int   p;
    @(negedge clk);
    rst          = r.rst;
    req_valid    = r.v;
    mem_ready    = r.mr;
    rsp_vin      = r.rv;
    rsp_tin      = r.rt;
    rsp_din      = 64'hFEED_0000_0000_0000 | 64'(idx);
    req_addr[0]  = 64'h8000_0040;
    req_addr[1]  = 64'h9000_0000 + 64'(idx);
    req_we       = 2'b10;
    req_wdata[0] = 64'hD000_0000_0000_0000 | 64'(idx);
    req_wdata[1] = 64'hD100_0000_0000_0000 | 64'(idx);
    #1;
    if (r.rst) begin
      sb.delete();
      return;
    end
    check($sformatf("req_ready[%0d]", idx), 64'(req_ready), 64'(r.rdy));
    check($sformatf("rsp_valid[%0d]", idx), 64'(rsp_valid), 64'(r.rsp));
    if (r.rsp != 2'b00) check($sformatf("rsp_data[%0d]", idx), rsp_data, rsp_din);
    check($sformatf("outstanding[%0d]", idx), 64'(outstanding), 64'(r.out));
    check($sformatf("mem_valid[%0d]", idx), 64'(mem_valid), 64'(r.mv));
    check($sformatf("err[%0d]", idx), 64'(err), 64'(r.err));
    if (r.hold) begin
      check($sformatf("hold_addr[%0d]", idx), mem_addr, 64'h8000_0040);
      check($sformatf("hold_tid[%0d]", idx), 64'(mem_tid), 64'd0);
    end
    if (r.mv && r.mr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow[%0d] actual=empty required=entry", idx);
      end else begin
        e = sb.pop_front();
        check($sformatf("mem_addr[%0d]", idx), mem_addr, e.addr);
        check($sformatf("mem_we[%0d]", idx), 64'(mem_we), 64'(e.we));
        check($sformatf("mem_wdata[%0d]", idx), mem_wdata, e.wdata);
        check($sformatf("mem_tid[%0d]", idx), 64'(mem_tid), 64'(e.tid));
      end
    end
    if (r.rdy != 2'b00) begin
      p       = r.rdy[1] ? PortDcache : PortIcache;
      e.addr  = req_addr[p];
      e.we    = req_we[p];
      e.wdata = req_wdata[p];
      e.tid   = r.tid;
      sb.push_back(e);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_we    = '0;
    req_wdata = '0;
    mem_ready = 1'b1;
    rsp_vin   = 1'b0;
    rsp_tin   = '0;
    rsp_din   = '0;

    // rst v  mr rv rt rdy    rsp    out mv err tid hold
    // alternating grants with immediate responses
    add(0, 2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 1, 0, 2'b10, 2'b01, 1, 1, 0, 1, 0);
    add(0, 2'b11, 1, 1, 1, 2'b01, 2'b10, 1, 1, 0, 0, 0);
    add(0, 2'b11, 1, 1, 0, 2'b10, 2'b01, 1, 1, 0, 1, 0);
    add(0, 2'b00, 1, 1, 1, 2'b00, 2'b10, 1, 1, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // fill all four TIDs, free TID 2, reallocate it, drain
    add(0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 1, 0);
    add(0, 2'b10, 1, 0, 0, 2'b10, 2'b00, 2, 1, 0, 2, 0);
    add(0, 2'b11, 1, 0, 0, 2'b01, 2'b00, 3, 1, 0, 3, 0);
    add(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 4, 1, 0, 0, 0);
    add(0, 2'b11, 1, 1, 2, 2'b00, 2'b10, 4, 0, 0, 0, 0);
    add(0, 2'b11, 1, 0, 0, 2'b10, 2'b00, 3, 0, 0, 2, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 4, 1, 0, 0, 0);
    add(0, 2'b00, 1, 1, 0, 2'b00, 2'b01, 4, 0, 0, 0, 0);
    add(0, 2'b00, 1, 1, 1, 2'b00, 2'b01, 3, 0, 0, 0, 0);
    add(0, 2'b00, 1, 1, 2, 2'b00, 2'b10, 2, 0, 0, 0, 0);
    add(0, 2'b00, 1, 1, 3, 2'b00, 2'b01, 1, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // memory stalls for five cycles with the request held
    add(0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    add(0, 2'b00, 1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // response on a free TID is sticky until reset
    add(0, 2'b00, 1, 1, 3, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    add(1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // reset with three IDs outstanding, then a stale response
    add(0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 1, 0);
    add(0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 2, 1, 0, 2, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 3, 1, 0, 0, 0);
    add(1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b00, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    add(0, 2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0);
    add(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_mem_valid", 64'(mem_valid), 64'd0);
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
`ifdef MEM_REQ_ARBITER_PERF_EN
    check("perf_grant0", 64'(perf_grant[0]), 64'd1);
    check("perf_grant1", 64'(perf_grant[1]), 64'd0);
    check("perf_stall0", 64'(perf_stall[0]), 64'd0);
    check("perf_stall1", 64'(perf_stall[1]), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
